// File: rtl/dm_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : dm_bus_bridge
// Description : Turns the core's single-cycle data-memory load/store into a
//               valid/ready request plus rvalid response bus transaction,
//               stalling the core until the access completes, then returns
//               load data and flags bus errors or timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_bus_bridge #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [ADDR_W-1:0] i_DM_addr,
   input  logic [DATA_W-1:0] i_DM_wd,
   input  logic [3:0]        i_DM_wen,
   input  logic              i_DM_ren,
   output logic [DATA_W-1:0] o_DM_rd,
   output logic              o_stall,
   output logic              o_err,
   output logic              o_bus_valid,
   output logic [ADDR_W-1:0] o_bus_addr,
   output logic [DATA_W-1:0] o_bus_wdata,
   output logic [3:0]        o_bus_be,
   output logic              o_bus_we,
   input  logic              i_bus_ready,
   input  logic              i_bus_rvalid,
   input  logic [DATA_W-1:0] i_bus_rdata,
   input  logic              i_bus_err
);

   localparam int         CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]        r_state;
   logic [1:0]        w_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wd;
   logic [3:0]        r_be;
   logic              r_we;
   logic              r_err;
   logic [DATA_W-1:0] r_rd;
   logic              w_req;
   logic              w_is_write;
   logic              w_timeout;

   assign w_is_write = |i_DM_wen;
   assign w_req      = i_DM_ren | w_is_write;
   // Last cycle allowed in REQ+RESP before the access is abandoned
   assign w_timeout  = (r_cnt >= CNT_W'(TIMEOUT - 1));

   // State register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state logic; a completing handshake beats a coincident timeout
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_req) w_next = S_REQ;
         S_REQ: begin
            if (i_bus_ready)    w_next = r_we ? S_DONE : S_RESP;
            else if (w_timeout) w_next = S_DONE;
         end
         S_RESP: if (i_bus_rvalid || w_timeout) w_next = S_DONE;
         default: w_next = S_IDLE;
      endcase
   end

   // Request capture, timeout counter, error latch and load data register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt  <= '0;
         r_addr <= '0;
         r_wd   <= '0;
         r_be   <= '0;
         r_we   <= 1'b0;
         r_err  <= 1'b0;
         r_rd   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  r_addr <= i_DM_addr;
                  r_wd   <= i_DM_wd;
                  r_be   <= w_is_write ? i_DM_wen : 4'hF;
                  r_we   <= w_is_write;
                  r_err  <= 1'b0;
                  r_cnt  <= '0;
               end
            end
            S_REQ: begin
               if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
               if (i_bus_ready) begin
                  if (r_we) r_err <= i_bus_err;
               end else if (w_timeout) begin
                  r_err <= 1'b1;
                  if (!r_we) r_rd <= '0;
               end
            end
            S_RESP: begin
               if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
               if (i_bus_rvalid) begin
                  r_rd  <= i_bus_rdata;
                  r_err <= i_bus_err;
               end else if (w_timeout) begin
                  r_err <= 1'b1;
                  r_rd  <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // Handshake and core-facing strobes decoded from state; reset masks the stall
   always_comb begin
      o_bus_valid = 1'b0;
      o_stall     = 1'b0;
      o_err       = 1'b0;
      case (r_state)
         S_IDLE: o_stall = w_req & ~i_rst;
         S_REQ: begin
            o_bus_valid = 1'b1;
            o_stall     = 1'b1;
         end
         S_RESP: o_stall = 1'b1;
         default: o_err = r_err;
      endcase
   end

   assign o_bus_addr  = r_addr;
   assign o_bus_wdata = r_wd;
   assign o_bus_be    = r_be;
   assign o_bus_we    = r_we;
   assign o_DM_rd     = r_rd;

endmodule
`default_nettype wire

// File: tb/tb_dm_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_bus_bridge
// Description : Directed self-checking bench for dm_bus_bridge (TIMEOUT = 8).
//               Inputs change on the falling edge; outputs are sampled 1 ns
//               later, i.e. well before the next rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_bus_bridge;

   logic        clk;
   logic        rst;
   logic [31:0] dm_addr;
   logic [31:0] dm_wd;
   logic [3:0]  dm_wen;
   logic        dm_ren;
   logic [31:0] dm_rd;
   logic        stall;
   logic        err;
   logic        bus_valid;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_we;
   logic        bus_ready;
   logic        bus_rvalid;
   logic [31:0] bus_rdata;
   logic        bus_err;

   int n_checks = 0;
   int n_errors = 0;

   dm_bus_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) u_dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_DM_addr    (dm_addr),
      .i_DM_wd      (dm_wd),
      .i_DM_wen     (dm_wen),
      .i_DM_ren     (dm_ren),
      .o_DM_rd      (dm_rd),
      .o_stall      (stall),
      .o_err        (err),
      .o_bus_valid  (bus_valid),
      .o_bus_addr   (bus_addr),
      .o_bus_wdata  (bus_wdata),
      .o_bus_be     (bus_be),
      .o_bus_we     (bus_we),
      .i_bus_ready  (bus_ready),
      .i_bus_rvalid (bus_rvalid),
      .i_bus_rdata  (bus_rdata),
      .i_bus_err    (bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance to the next falling edge (start of a new drive/sample window)
   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_core();
      dm_wen = 4'h0;
      dm_ren = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      dm_addr = '0; dm_wd = '0; dm_wen = '0; dm_ren = 1'b0;
      bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0; bus_err = 1'b0;

      // ---------------- reset state ----------------
      cyc(); cyc(); settle();
      check("rst_valid", {31'd0, bus_valid}, 32'd0);
      check("rst_stall", {31'd0, stall}, 32'd0);
      check("rst_err",   {31'd0, err}, 32'd0);
      check("rst_rd",    dm_rd, 32'd0);
      check("rst_addr",  bus_addr, 32'd0);
      check("rst_be",    {28'd0, bus_be}, 32'd0);
      check("rst_we",    {31'd0, bus_we}, 32'd0);
      rst = 1'b0;

      // ---------------- zero-wait write ----------------
      cyc();
      dm_wen = 4'b0011; dm_addr = 32'h100; dm_wd = 32'hDEADBEEF; bus_ready = 1'b1;
      settle();
      check("wr_idle_stall", {31'd0, stall}, 32'd1);
      check("wr_idle_valid", {31'd0, bus_valid}, 32'd0);
      cyc(); settle();                                  // REQ
      check("wr_req_valid", {31'd0, bus_valid}, 32'd1);
      check("wr_req_stall", {31'd0, stall}, 32'd1);
      check("wr_req_addr",  bus_addr, 32'h100);
      check("wr_req_wdata", bus_wdata, 32'hDEADBEEF);
      check("wr_req_be",    {28'd0, bus_be}, 32'h3);
      check("wr_req_we",    {31'd0, bus_we}, 32'd1);
      cyc(); settle();                                  // DONE
      check("wr_done_stall", {31'd0, stall}, 32'd0);
      check("wr_done_valid", {31'd0, bus_valid}, 32'd0);
      check("wr_done_err",   {31'd0, err}, 32'd0);
      check("wr_done_rd",    dm_rd, 32'd0);
      cyc(); idle_core(); bus_ready = 1'b0; settle();   // IDLE
      check("wr_after_valid", {31'd0, bus_valid}, 32'd0);
      check("wr_after_stall", {31'd0, stall}, 32'd0);

      // ---------------- read with wait states ----------------
      cyc();
      dm_ren = 1'b1; dm_addr = 32'h200; settle();
      check("rd_idle_stall", {31'd0, stall}, 32'd1);
      cyc(); settle();                                  // REQ, cnt 0
      check("rd_req_valid", {31'd0, bus_valid}, 32'd1);
      check("rd_req_be",    {28'd0, bus_be}, 32'hF);
      check("rd_req_we",    {31'd0, bus_we}, 32'd0);
      check("rd_req_addr",  bus_addr, 32'h200);
      cyc(); settle();                                  // REQ, cnt 1
      check("rd_wait_valid", {31'd0, bus_valid}, 32'd1);
      cyc();                                            // REQ: ready, early rvalid
      bus_ready = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hBAD0BAD0; settle();
      cyc();                                            // RESP
      bus_ready = 1'b0; bus_rvalid = 1'b0; settle();
      check("rd_resp_valid", {31'd0, bus_valid}, 32'd0);
      check("rd_resp_stall", {31'd0, stall}, 32'd1);
      cyc(); settle();                                  // RESP
      cyc();                                            // RESP: real rvalid
      bus_rvalid = 1'b1; bus_rdata = 32'h12345678; settle();
      check("rd_resp2_stall", {31'd0, stall}, 32'd1);
      cyc(); bus_rvalid = 1'b0; bus_rdata = '0; settle(); // DONE
      check("rd_done_rd",    dm_rd, 32'h12345678);
      check("rd_done_err",   {31'd0, err}, 32'd0);
      check("rd_done_stall", {31'd0, stall}, 32'd0);
      cyc(); idle_core(); settle();
      check("rd_hold_rd", dm_rd, 32'h12345678);

      // ---------------- write with bus error ----------------
      cyc();
      dm_wen = 4'hF; dm_addr = 32'h300; dm_wd = 32'h0; bus_err = 1'b1; settle();
      cyc(); bus_ready = 1'b1; settle();                // REQ, error at ready
      check("be_req_err", {31'd0, err}, 32'd0);
      cyc(); bus_ready = 1'b0; settle();                // DONE
      check("be_done_err", {31'd0, err}, 32'd1);
      check("be_done_rd",  dm_rd, 32'h12345678);
      cyc(); idle_core(); bus_err = 1'b0; settle();     // IDLE
      check("be_idle_err", {31'd0, err}, 32'd0);

      // ---------------- read timeout (8 cycles in REQ) ----------------
      cyc();
      dm_ren = 1'b1; dm_addr = 32'h500; settle();
      for (int i = 0; i < 8; i++) begin
         cyc(); settle();
         check($sformatf("to_req%0d_valid", i), {31'd0, bus_valid}, 32'd1);
      end
      cyc(); settle();                                  // DONE
      check("to_done_err",   {31'd0, err}, 32'd1);
      check("to_done_rd",    dm_rd, 32'd0);
      check("to_done_valid", {31'd0, bus_valid}, 32'd0);
      check("to_done_stall", {31'd0, stall}, 32'd0);
      cyc(); idle_core();                               // late response
      bus_ready = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hAAAA5555; settle();
      check("to_late_valid", {31'd0, bus_valid}, 32'd0);
      check("to_late_stall", {31'd0, stall}, 32'd0);
      cyc(); bus_ready = 1'b0; bus_rvalid = 1'b0; settle();
      check("to_late_rd",  dm_rd, 32'd0);
      check("to_late_err", {31'd0, err}, 32'd0);

      // ---------------- write wins over read ----------------
      cyc();
      dm_ren = 1'b1; dm_wen = 4'hF; dm_addr = 32'h600; dm_wd = 32'hCAFEF00D; settle();
      cyc(); settle();
      check("pri_we",    {31'd0, bus_we}, 32'd1);
      check("pri_be",    {28'd0, bus_be}, 32'hF);
      check("pri_wdata", bus_wdata, 32'hCAFEF00D);
      bus_ready = 1'b1;
      cyc(); bus_ready = 1'b0; settle();                // DONE
      check("pri_done_stall", {31'd0, stall}, 32'd0);
      cyc(); idle_core(); settle();

      // ---------------- back-to-back loads ----------------
      cyc();
      dm_ren = 1'b1; dm_addr = 32'h400; bus_ready = 1'b1; settle();
      cyc(); settle();                                  // REQ
      check("b2b1_addr", bus_addr, 32'h400);
      cyc(); bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h11111111; settle(); // RESP
      check("b2b1_resp_stall", {31'd0, stall}, 32'd1);
      cyc(); bus_rvalid = 1'b0; settle();               // DONE
      check("b2b1_done_rd", dm_rd, 32'h11111111);
      check("b2b1_done_stall", {31'd0, stall}, 32'd0);
      cyc(); dm_addr = 32'h404; bus_ready = 1'b1; settle(); // IDLE, next load
      check("b2b2_idle_stall", {31'd0, stall}, 32'd1);
      check("b2b2_idle_valid", {31'd0, bus_valid}, 32'd0);
      cyc(); settle();                                  // REQ
      check("b2b2_addr",  bus_addr, 32'h404);
      check("b2b2_valid", {31'd0, bus_valid}, 32'd1);
      cyc(); bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h22222222; settle();
      cyc(); bus_rvalid = 1'b0; settle();               // DONE
      check("b2b2_done_rd", dm_rd, 32'h22222222);
      check("b2b2_done_err", {31'd0, err}, 32'd0);
      cyc(); idle_core(); settle();

      // ---------------- asynchronous reset in REQ ----------------
      cyc();
      dm_ren = 1'b1; dm_addr = 32'h700; settle();
      cyc(); settle();                                  // REQ
      check("ar_pre_valid", {31'd0, bus_valid}, 32'd1);
      rst = 1'b1; settle();                             // mid-cycle, no edge
      check("ar_valid", {31'd0, bus_valid}, 32'd0);
      check("ar_stall", {31'd0, stall}, 32'd0);
      check("ar_addr",  bus_addr, 32'd0);
      check("ar_rd",    dm_rd, 32'd0);
      check("ar_be",    {28'd0, bus_be}, 32'd0);
      cyc(); idle_core(); rst = 1'b0; settle();
      check("ar_idle_valid", {31'd0, bus_valid}, 32'd0);
      check("ar_idle_stall", {31'd0, stall}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   // Absolute bound on simulated time
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
